// File: rtl/mdu_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
// Helpers work on a fixed wide vector; callers size-cast operands in and results out.
package mdu_pkg;

  localparam int unsigned MDU_DEFAULT_WIDTH = 32;
  // Helper vector width; covers 2*WIDTH products for WIDTH up to 64.
  localparam int unsigned MDU_FN_W = 128;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN_MUL = 2'd1,
    RUN_DIV = 2'd2
  } mdu_state_e;

  function automatic logic [MDU_FN_W-1:0] mdu_neg(input logic [MDU_FN_W-1:0] x);
    return (~x) + MDU_FN_W'(1);
  endfunction

  function automatic logic [MDU_FN_W-1:0] mdu_abs(input logic [MDU_FN_W-1:0] x,
                                                 input logic is_neg);
    return is_neg ? mdu_neg(x) : x;
  endfunction

endpackage

// File: rtl/mdu.sv
// Bit-serial multiply/divide unit with architectural HI/LO for the MIPS EX stage.
// Magnitudes are iterated in acc_q/opnd_q; sign fix-up is applied on the final edge.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned W2 = 2 * WIDTH;

  mdu_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  mdu_op_e          op_e;
  logic             signed_op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum, div_diff;
  logic [W2-1:0]    mul_next, div_next, step_next, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign op_e      = mdu_op_e'(op);
  assign signed_op = (op_e == OP_MULT) || (op_e == OP_DIV);
  assign a_neg     = signed_op & in1[WIDTH-1];
  assign b_neg     = signed_op & in2[WIDTH-1];
  assign abs_a     = WIDTH'(mdu_abs(MDU_FN_W'(in1), a_neg));
  assign abs_b     = WIDTH'(mdu_abs(MDU_FN_W'(in2), b_neg));

  // Shift-add: acc holds {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide: acc holds {remainder, dividend bits -> quotient bits}.
  assign div_diff = acc_q[W2-1:WIDTH-1] - {1'b0, opnd_q};
  assign div_next = div_diff[WIDTH] ? {acc_q[W2-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign step_next = (state_q == RUN_MUL) ? mul_next : div_next;
  assign prod_fix  = neg_a_q ? W2'(mdu_neg(MDU_FN_W'(step_next))) : step_next;
  assign quo_fix   = neg_a_q ? WIDTH'(mdu_neg(MDU_FN_W'(step_next[WIDTH-1:0])))
                             : step_next[WIDTH-1:0];
  assign rem_fix   = neg_b_q ? WIDTH'(mdu_neg(MDU_FN_W'(step_next[W2-1:WIDTH])))
                             : step_next[W2-1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          case (op_e)
            OP_MULT, OP_MULTU: begin
              state_d = RUN_MUL;
              cnt_d   = CW'(WIDTH);
              acc_d   = {{WIDTH{1'b0}}, abs_b};
              opnd_d  = abs_a;
              neg_a_d = a_neg ^ b_neg;
              neg_b_d = 1'b0;
            end
            OP_DIV, OP_DIVU: begin
              if (in2 == '0) begin
                lo_d   = '1;
                hi_d   = in1;
                dz_d   = 1'b1;
                done_d = 1'b1;
              end else begin
                state_d = RUN_DIV;
                cnt_d   = CW'(WIDTH);
                acc_d   = {{WIDTH{1'b0}}, abs_a};
                opnd_d  = abs_b;
                neg_a_d = a_neg ^ b_neg;
                neg_b_d = a_neg;
              end
            end
            OP_MTHI: hi_d = in1;
            OP_MTLO: lo_d = in1;
            default: ;
          endcase
        end
      end
      RUN_MUL, RUN_DIV: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = step_next;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            dz_d    = 1'b0;
            if (state_q == RUN_MUL) begin
              {hi_d, lo_d} = prod_fix;
            end else begin
              lo_d = quo_fix;
              hi_d = rem_fix;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
